seg_scan_ctrl: RTL and testbench

Time-multiplexing controller for the board's 8-digit seven-segment display. It sequences the common anodes, selects the nibble and decimal point for the external led_display decoder, and inserts an anti-ghosting blank at the start of every digit slot. It applies optional leading-zero suppression and a per-digit enable mask. Display data is captured into a shadow register once per frame, so a digit never shows a value that changed partway through its slot.

---
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit seven-segment display.
// Sequences the common anodes, picks the nibble and decimal point for the segment decoder,
// blanks the anodes at the start of every slot, and takes a frame-atomic shadow copy of the
// display inputs.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS    = 8,
   parameter int unsigned DWELL     = 2500,
   parameter int unsigned BLANK_GAP = 25,
   localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] data_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   digit_en,
   input  logic                lz_blank,
   output logic [DIGITS-1:0]   an,
   output logic [3:0]          nibble,
   output logic                dp,
   output logic [SW-1:0]       sel,
   output logic                frame_done
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [SW-1:0] SEL_LAST = SW'(DIGITS - 1);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SW-1:0]       sel_q, sel_d;
   logic [4*DIGITS-1:0] sh_data_q;
   logic [DIGITS-1:0]   sh_dp_q, sh_en_q;
   logic                sh_lz_q;
   logic                frame_done_q;

   logic                slot_end, frame_end;
   logic                gap_done;
   logic [DIGITS-1:0]   lz;
   logic                upper_zero;
   logic                cur_en, cur_lz;

   // Prescaler and slot index next-state; frame_end marks the shadow reload edge
   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (sel_q == SEL_LAST);
      cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
      sel_d     = sel_q;
      if (slot_end) begin
         sel_d = frame_end ? '0 : sel_q + 1'b1;
      end
   end

   // Scan counters, shadow registers and frame pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         sel_q        <= '0;
         sh_data_q    <= '0;
         sh_dp_q      <= '0;
         sh_en_q      <= '0;
         sh_lz_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_end;
         if (frame_end) begin
            sh_data_q <= data_in;
            sh_dp_q   <= dp_in;
            sh_en_q   <= digit_en;
            sh_lz_q   <= lz_blank;
         end
      end
   end

   // Anti-ghosting gap: with a zero gap the anode may switch straight to the next digit
   if (BLANK_GAP == 0) begin : g_no_gap
      assign gap_done = 1'b1;
   end else begin : g_gap
      assign gap_done = (cnt_q >= CW'(BLANK_GAP));
   end

   // Leading-zero mask: a digit is suppressed when it and every digit above it is zero
   always_comb begin
      lz         = '0;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (sh_data_q[4*i +: 4] == 4'h0);
         if (i != 0) begin
            lz[i] = sh_lz_q && upper_zero;
         end
      end
   end

   // Output decode for the current slot; nibble and dp ignore blanking
   always_comb begin
      nibble = 4'h0;
      dp     = 1'b0;
      cur_en = 1'b0;
      cur_lz = 1'b0;
      an     = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (sel_q == SW'(i)) begin
            nibble = sh_data_q[4*i +: 4];
            dp     = sh_dp_q[i];
            cur_en = sh_en_q[i];
            cur_lz = lz[i];
         end
      end
      if (gap_done && cur_en && !cur_lz) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (sel_q == SW'(i)) begin
               an[i] = 1'b0;
            end
         end
      end
   end

   assign sel        = sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle blank gap).
// The reference model tracks elapsed cycles since reset release and derives slot, position
// and frame reloads arithmetically.
module tb_seg_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int DWELL  = 8;
   localparam int GAP    = 2;
   localparam int FRAME  = DIGITS * DWELL;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  digit_en = 4'h0;
   logic        lz_blank = 1'b0;
   logic [3:0]  an;
   logic [3:0]  nibble;
   logic        dp;
   logic [1:0]  sel;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: edges since release, and the shadow copy taken at each frame boundary
   int          k = 0;
   logic [15:0] m_data = 16'h0;
   logic [3:0]  m_dp = 4'h0;
   logic [3:0]  m_en = 4'h0;
   logic        m_lz = 1'b0;
   logic        m_fd = 1'b0;

   seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK_GAP(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .lz_blank   (lz_blank),
      .an         (an),
      .nibble     (nibble),
      .dp         (dp),
      .sel        (sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   function automatic int slot_of();
      return (k / DWELL) % DIGITS;
   endfunction

   function automatic int pos_of();
      return k % DWELL;
   endfunction

   function automatic logic [3:0] exp_an();
      int         s;
      logic       sup, on;
      logic [3:0] one;
      s   = slot_of();
      sup = m_lz && (s != 0) && ((m_data >> (4 * s)) == 16'h0);
      on  = (pos_of() >= GAP) && m_en[s] && !sup;
      one = 4'b0001;
      return on ? ~(one << s) : 4'hF;
   endfunction

   task automatic chk_reset();
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_nibble", 32'(nibble), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_fd", 32'(frame_done), 32'h0);
   endtask

   // One clock: advance the model, capture the shadow at frame boundaries, then check
   task automatic step();
      int s;
      @(posedge clk);
      k++;
      m_fd = ((k % FRAME) == 0);
      if (m_fd) begin
         m_data = data_in;
         m_dp   = dp_in;
         m_en   = digit_en;
         m_lz   = lz_blank;
      end
      #1;
      s = slot_of();
      chk("an", 32'(an), 32'(exp_an()));
      chk("sel", 32'(sel), 32'(s));
      chk("nibble", 32'(nibble), 32'((m_data >> (4 * s)) & 16'hF));
      chk("dp", 32'(dp), 32'(m_dp[s]));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst    = 1'b1;
      k      = 0;
      m_data = 16'h0;
      m_dp   = 4'h0;
      m_en   = 4'h0;
      m_lz   = 1'b0;
   endtask

   initial begin
      // Reset and first frame: dark until the first reload at cycle 32
      data_in  = 16'h1234;
      digit_en = 4'hF;
      #2 chk_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 chk_reset();
      end
      release_rst();
      run(2 * FRAME);

      // Leading-zero suppression
      data_in  = 16'h0040;
      lz_blank = 1'b1;
      run(2 * FRAME);
      data_in = 16'h0000;
      run(2 * FRAME);

      // Frame-atomic update: change inputs while sel==1
      data_in  = 16'h1111;
      lz_blank = 1'b0;
      run(FRAME);
      for (int i = 0; i < FRAME && slot_of() != 1; i++) step();
      chk("reach_sel1", 32'(slot_of()), 32'h1);
      data_in = 16'h2222;
      run(2 * FRAME);

      // Digit enable and decimal point
      digit_en = 4'b0101;
      dp_in    = 4'b0010;
      run(2 * FRAME);

      // Asynchronous reset mid-slot at sel=2, cnt=5
      digit_en = 4'hF;
      for (int i = 0; i < 2 * FRAME && !(slot_of() == 2 && pos_of() == 5); i++) step();
      chk("reach_s2c5", 32'(slot_of() * 16 + pos_of()), 32'h25);
      #1 rst = 1'b0;
      #1 chk_reset();
      @(posedge clk);
      #1 chk_reset();
      release_rst();
      run(2 * FRAME);

      // Randomized inputs changed at random points within each frame
      for (int f = 0; f < 20; f++) begin
         int cut;
         cut = int'($urandom_range(FRAME - 1, 0));
         run(cut);
         data_in  = 16'($urandom);
         dp_in    = 4'($urandom);
         digit_en = 4'($urandom);
         lz_blank = 1'($urandom);
         if (f % 4 == 0) data_in = data_in & 16'h00FF;
         run(FRAME - cut);
      end
      run(FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
